// File: rtl/passcode_pkg.sv
// Shared types and widths for the passcode checker.
package passcode_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned FAIL_W     = 3;

  typedef enum logic [2:0] {
    StEntry,
    StCheck,
    StUnlocked,
    StError,
    StLockout
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: pulses while the level is high and its registered copy is low.
module rise_detect (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Level,
  output logic o_Rise
);

  logic level_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_Level;
    end
  end

  assign o_Rise = i_Level & ~level_q;

endmodule

// File: rtl/passcode_checker.sv
// Assembles four Enter-captured digits, compares against a fixed code and tracks
// unlock / retry / timed lockout status.
module passcode_checker
  import passcode_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] CODE_D0        = 4'd1,
  parameter logic [DIGIT_W-1:0] CODE_D1        = 4'd2,
  parameter logic [DIGIT_W-1:0] CODE_D2        = 4'd3,
  parameter logic [DIGIT_W-1:0] CODE_D3        = 4'd4,
  parameter int unsigned        MAX_TRIES      = 3,
  parameter int unsigned        LOCKOUT_CYCLES = 25_000_000
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [DIGIT_W-1:0] i_Digit,
  input  logic               i_Enter,
  input  logic               i_Clear,
  output logic               o_Unlocked,
  output logic               o_Error,
  output logic               o_Locked_Out,
  output logic [IDX_W-1:0]   o_Digit_Index,
  output logic [FAIL_W-1:0]  o_Fail_Count
);

  localparam int unsigned   CntW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCKOUT_CYCLES - 1);

  logic enter_rise, clear_rise;

  rise_detect u_enter_rise (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Level (i_Enter),
    .o_Rise  (enter_rise)
  );

  rise_detect u_clear_rise (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Level (i_Clear),
    .o_Rise  (clear_rise)
  );

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DIGIT_W-1:0]  slot_q [NUM_DIGITS];
  logic                slot_we;
  logic                code_match;
  logic                unlocked_q, error_q, locked_q;

  // Codes are 0-9, so slot values 10-15 can never compare equal.
  assign code_match = (slot_q[0] == CODE_D0) && (slot_q[1] == CODE_D1) &&
                      (slot_q[2] == CODE_D2) && (slot_q[3] == CODE_D3);
  assign fail_inc   = fail_q + FAIL_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    slot_we = 1'b0;
    case (state_q)
      StEntry: begin
        if (clear_rise) begin
          idx_d = '0;
        end else if (enter_rise) begin
          slot_we = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) state_d = StCheck;
        end
      end
      StCheck: begin
        if (code_match) begin
          state_d = StUnlocked;
          fail_d  = '0;
        end else begin
          fail_d  = fail_inc;
          cnt_d   = '0;
          state_d = (fail_inc == FAIL_W'(MAX_TRIES)) ? StLockout : StError;
        end
      end
      StUnlocked: begin
        if (clear_rise) begin
          state_d = StEntry;
          idx_d   = '0;
        end
      end
      StError: begin
        // The Enter that leaves ERROR only re-arms entry; it captures nothing.
        if (clear_rise || enter_rise) begin
          state_d = StEntry;
          idx_d   = '0;
        end
      end
      StLockout: begin
        if (cnt_q == CntLast) begin
          state_d = StEntry;
          cnt_d   = '0;
          fail_d  = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= StEntry;
      idx_q      <= '0;
      fail_q     <= '0;
      cnt_q      <= '0;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      cnt_q      <= cnt_d;
      unlocked_q <= (state_d == StUnlocked);
      error_q    <= (state_d == StError);
      locked_q   <= (state_d == StLockout);
      if (slot_we) slot_q[idx_q[1:0]] <= i_Digit;
    end
  end

  assign o_Unlocked    = unlocked_q;
  assign o_Error       = error_q;
  assign o_Locked_Out  = locked_q;
  assign o_Digit_Index = idx_q;
  assign o_Fail_Count  = fail_q;

endmodule

// File: doc/passcode_checker.md
# passcode_checker

Consumes the 4-bit decimal digit produced by the switch-driven digit counter and assembles a 4-digit passcode from successive Enter presses. After the fourth digit it compares the sequence against a parameterised code, then raises unlock, error or lockout status for the display/LED logic. It sits between the digit counter and the lock outputs as the verifying end of the digit-entry path.

## Interface
- CODE_D0, default 4'd1: first code digit (0-9)
- CODE_D1, default 4'd2: second code digit
- CODE_D2, default 4'd3: third code digit
- CODE_D3, default 4'd4: fourth code digit
- MAX_TRIES, default 3: failed attempts that trigger lockout (1-7)
- LOCKOUT_CYCLES, default 25_000_000: lockout duration in clocks (1 s at 25 MHz)
- i_Clk  in  1  system clock, the only clock domain
- i_Reset  in  1  synchronous reset, active-high
- i_Digit  in  4  current digit from the digit counter, sampled on Enter
- i_Enter  in  1  Enter switch level, already synchronised
- i_Clear  in  1  Clear switch level, already synchronised
- o_Unlocked  out  1  code accepted
- o_Error  out  1  last attempt wrong, retry allowed
- o_Locked_Out  out  1  lockout timer running
- o_Digit_Index  out  3  digits captured in current attempt (0-4)
- o_Fail_Count  out  3  consecutive failed attempts

## Operation
- Rising edge of i_Enter/i_Clear: input high this edge and registered copy low; registered copies reset to 0.
- States: ENTRY, CHECK, UNLOCKED, ERROR, LOCKOUT. Reset -> ENTRY, index 0, fail count 0, lockout counter 0, all flags 0.
- ENTRY: Enter rise stores i_Digit in slot[index], index+1. Capture of the 4th digit -> CHECK. Clear rise -> index 0, fail count unchanged.
- CHECK (one cycle): all four slots equal CODE_D0..D3 -> UNLOCKED, fail count 0. Otherwise fail count+1; new count == MAX_TRIES -> LOCKOUT, else ERROR. Slot values 10-15 never match.
- UNLOCKED: holds; Enter ignored; Clear rise -> ENTRY, index 0.
- ERROR: Enter rise or Clear rise -> ENTRY, index 0; that Enter does not capture a digit.
- LOCKOUT: all inputs ignored; counter runs 0..LOCKOUT_CYCLES-1, then -> ENTRY, fail count 0, index 0.
- Simultaneous Enter and Clear rise: Clear wins in every state.
- Reset mid-operation (any state, including LOCKOUT) returns to reset state on that edge; partial entries lost.
- Outputs are registered decodes of state: o_Unlocked = UNLOCKED, o_Error = ERROR, o_Locked_Out = LOCKOUT.

## Timing
- Digit captured on the same edge that detects the Enter rise; o_Digit_Index updates that edge.
- 4th-digit edge N -> CHECK after N; result state and flag visible after edge N+1 (2-cycle latency from the detecting edge).
- Held Enter counts once; re-arming needs one low sample.
- LOCKOUT lasts exactly LOCKOUT_CYCLES clocks; o_Locked_Out high for exactly that many cycles.
- o_Fail_Count updates on CHECK exit edge; saturates at MAX_TRIES and clears on lockout exit.

## Structure
- Package passcode_pkg: state enum, DIGIT_W = 4, NUM_DIGITS = 4, fail-count width.
- Sub-module rise_detect (1-bit registered rising-edge detector with sync reset), instantiated for Enter and Clear.
- Digit slots, FSM and lockout counter live in passcode_checker.

## Test plan
Parameters: code 1-2-3-4, MAX_TRIES 3, LOCKOUT_CYCLES 8.
- Digits 1,2,3,4 with Enter pulses -> o_Unlocked high 2 cycles after 4th rise, o_Fail_Count 0; Clear rise -> ENTRY, index 0.
- Digits 1,2,3,5 -> o_Error, o_Fail_Count 1; Enter rise -> ENTRY, index 0, no digit stored.
- Three wrong codes -> o_Locked_Out high exactly 8 cycles, Enter pulses ignored, then ENTRY with fail count 0.
- Enter held high 20 cycles with digit 1 -> o_Digit_Index 1; entry 1,2 then Clear -> index 0; Enter and Clear rise same edge -> index 0, no capture.
- i_Reset during LOCKOUT at cycle 3 -> next cycle all outputs 0, ENTRY; correct code then unlocks.
- Digit 12 in slot 2 -> mismatch, o_Error, fail count 1.
